falcon_uart_tx: RTL and testbench
=================================

# falcon_uart_tx

Byte-serial UART transmitter (8N1, LSB first) for the Falcon TinyTapeout design. It accepts bytes from core logic over a valid/ready handshake and buffers them in a small FIFO. It drives a single serial line, routed to a dedicated output pin (uo_out bit), to an external receiver or the cocotb bench UART model. It is the transmit-side counterpart to the byte streams the bench drives into the design on ui_in.

## Interface

Parameters:
- CLKS_PER_BIT, 87: clock cycles per serial bit (10 MHz / 115200). Legal range ≥ 2.
- FIFO_DEPTH, 4: FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- tx_data  in  8  byte to send; sampled when tx_valid && tx_ready
- tx_valid  in  1  producer has a byte
- tx_ready  out  1  FIFO not full
- tx  out  1  serial line; idles high
- busy  out  1  frame in progress or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held in FIFO

## Operation

- Push: on a rising edge where tx_valid && tx_ready, tx_data is written to the FIFO.
- tx_ready = !full. The producer must hold tx_data/tx_valid until accepted. No byte is dropped or duplicated.
- State machine (encoding lives in the package): IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the bit-timer, and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP, if the FIFO is non-empty, pop directly and go to START (no idle gap). Otherwise go to IDLE.
- tx is a registered output (glitch-free pin).
- busy = (state != IDLE) || (fifo_count != 0).
- Simultaneous push and pop in the same cycle: fifo_count is unchanged and both take effect. A push is never accepted while full, even if a pop occurs that cycle.
- Bit-timer width: $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps at the bit boundary. Bit index is 3 bits.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. full/empty are derived from fifo_count.

## Timing

- Reset values (asynchronous, effective immediately on rst assertion): tx=1, tx_ready=1, busy=0, fifo_count=0, state=IDLE, FIFO emptied.
- Reset mid-frame: the partial frame is abandoned and tx returns high in the same cycle rst rises. Buffered bytes are discarded.
- Latency from an idle state: a handshake at edge E0 gives fifo_count=1 after E0. The pop happens at E1, and tx goes low after E1. The start bit is visible 1 cycle after acceptance.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are contiguous, so the period is 10*CLKS_PER_BIT.
- busy deasserts on the edge that ends the last STOP bit, when the FIFO is empty.
- tx_ready reflects the registered fifo_count, with no combinational path from tx_valid.
- Capacity: with an idle transmitter and continuous valid, FIFO_DEPTH+1 bytes are accepted before tx_ready drops, because one byte moves into the shifter.

## Structure

- falcon_pkg: state enum typedef (IDLE/START/DATA/STOP), UART_DATA_BITS=8, default CLKS_PER_BIT constant.
- Sub-module falcon_sync_fifo:
  - parameterized width/depth; same clk and rst
  - ports: push/pop, wdata/rdata, count, full, empty
  - reused later by the receive path
- The top level holds the FSM, the bit-timer, the bit index, and the shift register.

## Test plan

Run at CLKS_PER_BIT=4, FIFO_DEPTH=4. A bench UART model samples tx at mid-bit.
- Reset: assert rst with no clock activity → tx=1, tx_ready=1, busy=0, fifo_count=0.
- Single byte 0xA5 pushed at E0 → tx low after E1. Then bits 1,0,1,0,0,1,0,1, each held 4 cycles. Then stop=1. busy=0 exactly 40 cycles after tx fell. The model decodes 0xA5.
- Burst 0x00,0xFF,0x55,0x0F,0x3C,0x81 with valid held continuously:
  - first 5 accepted, tx_ready low with fifo_count=4
  - 0x81 accepted once a pop frees an entry
  - 6 contiguous frames (240 cycles, no extra idle) decode in order
- Reset during DATA bit 3 of 0x3C with 2 bytes queued → tx=1 in the same cycle, fifo_count=0, busy=0. After release, push 0x81 → decodes correctly. Nothing from before the reset is emitted.
- Valid toggled randomly against full/ready backpressure, 32 random bytes → every byte decoded exactly once, in order. fifo_count never exceeds 4.

Source files
------------

// File: rtl/falcon_pkg.sv
// Shared UART definitions for the Falcon design: transmitter states and framing constants.
// The receive path is expected to import the same package.
package falcon_pkg;

   localparam int unsigned UART_DATA_BITS       = 8;
   localparam int unsigned DEFAULT_CLKS_PER_BIT = 87;  // 10 MHz / 115200 baud

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/falcon_sync_fifo.sv
// Single-clock FIFO with an occupancy counter; full/empty are derived from the count.
// Read data is the current head (show-ahead), valid whenever empty is low.
module falcon_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Requests are gated here so a caller can never overflow or underflow the buffer.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/falcon_uart_tx.sv
// 8N1 UART transmitter, LSB first, fed from a small FIFO over a valid/ready handshake.
// Back-to-back bytes are sent as contiguous frames with no idle gap between them.
module falcon_uart_tx
   import falcon_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [UART_DATA_BITS-1:0]     tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

   uart_state_t                state;
   logic [TW-1:0]              timer;
   logic [2:0]                 bit_idx;
   logic [UART_DATA_BITS-1:0]  shift;
   logic [UART_DATA_BITS-1:0]  fifo_rdata;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       push;
   logic                       pop;
   logic                       bit_done;

   assign bit_done = (timer == TIMER_MAX);
   assign tx_ready = !fifo_full;
   assign push     = tx_valid && !fifo_full;
   // Pop either from idle or exactly at the end of a stop bit, which keeps frames contiguous.
   assign pop      = !fifo_empty && ((state == StIdle) || ((state == StStop) && bit_done));
   assign busy     = (state != StIdle) || (fifo_count != '0);

   falcon_sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (tx_data),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= StIdle;
         timer   <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         case (state)
            StIdle: begin
               tx    <= 1'b1;
               timer <= '0;
               if (pop) begin
                  shift <= fifo_rdata;
                  tx    <= 1'b0;
                  state <= StStart;
               end
            end

            StStart: begin
               if (bit_done) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  tx      <= shift[0];
                  state   <= StData;
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            StData: begin
               if (bit_done) begin
                  timer <= '0;
                  if (bit_idx == LAST_BIT) begin
                     tx    <= 1'b1;
                     state <= StStop;
                  end else begin
                     // Drive the next bit now so tx stays a pure register output.
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            StStop: begin
               if (bit_done) begin
                  timer <= '0;
                  if (pop) begin
                     shift <= fifo_rdata;
                     tx    <= 1'b0;
                     state <= StStart;
                  end else begin
                     state <= StIdle;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            default: begin
               tx    <= 1'b1;
               timer <= '0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_falcon_uart_tx.sv
// Bench for falcon_uart_tx at 4 clocks per bit: a mid-bit sampling UART receiver decodes
// the line and its output is compared with the bytes the bench handed over.
module tb_falcon_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rst_seen = 0;
   int frame_err = 0;
   int max_cnt = 0;
   logic track_max = 1'b0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int         start_q[$];

   falcon_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 if (clk_en) clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge rst) rst_seen <= rst_seen + 1;
   always @(negedge clk) if (track_max && int'(fifo_count) > max_cnt) max_cnt <= int'(fifo_count);

   // Receiver model: start edge seen at a falling-edge sample, then sample each bit near its middle.
   initial begin
      logic [7:0] b;
      logic       ok;
      logic       stop_bit;
      logic       abort;
      int         rs;
      int         st;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            st = cyc;
            rs = rst_seen;
            b = '0;
            ok = 1'b1;
            stop_bit = 1'b0;
            abort = 1'b0;
            for (int i = 1; i <= 37 && !abort; i++) begin
               @(negedge clk);
               if (rst || rst_seen != rs) abort = 1'b1;
               else if (i == 1) ok = (tx === 1'b0);
               else if ((i - 1) % CPB == 0 && i <= 33) b[(i - 1) / CPB - 1] = tx;
               else if (i == 37) stop_bit = tx;
            end
            if (!abort) begin
               got_q.push_back(b);
               start_q.push_back(st);
               if (!ok || stop_bit !== 1'b1) frame_err++;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; holds valid/data until accepted or the limit expires.
   task automatic push_byte(input logic [7:0] b, input int limit, output int waited);
      logic acc;
      acc = 1'b0;
      waited = 0;
      tx_valid = 1'b1;
      tx_data = b;
      while (!acc && waited < limit) begin
         acc = (tx_ready === 1'b1);
         @(negedge clk);
         waited++;
      end
      if (acc) exp_q.push_back(b);
      check("push_accepted", 32'(acc), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle_in_time"}, 32'(n < limit), 32'd1);
   endtask

   task automatic compare_frames(input string tag);
      int n;
      check({tag, "_frame_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
      check({tag, "_framing"}, 32'(frame_err), 32'd0);
      got_q.delete();
      exp_q.delete();
      start_q.delete();
   endtask

   initial begin
      logic [9:0] fr;
      logic [7:0] burst[6];
      int         mism;
      int         w;
      int         gaps;
      int         gap;

      // Reset with no clock running.
      #2 rst = 1'b1;
      #2;
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_ready", 32'(tx_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_count", 32'(fifo_count), 32'd0);
      clk_en = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single byte: exact waveform and busy timing.
      push_byte(8'hA5, 2, w);
      tx_valid = 1'b0;
      check("a5_count_after_push", 32'(fifo_count), 32'd1);
      check("a5_tx_before_pop", 32'(tx), 32'd1);
      @(negedge clk);
      check("a5_count_after_pop", 32'(fifo_count), 32'd0);
      fr = {1'b1, 8'hA5, 1'b0};
      mism = 0;
      for (int i = 0; i < 10 * CPB; i++) begin
         if (tx !== fr[i / CPB]) mism++;
         if (i == 10 * CPB - 1) check("a5_busy_last_cycle", 32'(busy), 32'd1);
         @(negedge clk);
      end
      check("a5_waveform_mismatches", 32'(mism), 32'd0);
      check("a5_busy_after_frame", 32'(busy), 32'd0);
      check("a5_tx_idle", 32'(tx), 32'd1);
      compare_frames("a5");

      // Burst with continuous valid: capacity, backpressure, contiguity.
      burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h55;
      burst[3] = 8'h0F; burst[4] = 8'h3C; burst[5] = 8'h81;
      for (int k = 0; k < 5; k++) push_byte(burst[k], 2, w);
      check("burst_full_count", 32'(fifo_count), 32'd4);
      check("burst_full_ready", 32'(tx_ready), 32'd0);
      push_byte(burst[5], 60, w);
      check("burst_6th_backpressured", 32'(w > 30), 32'd1);
      tx_valid = 1'b0;
      wait_idle("burst", 400);
      gaps = 0;
      for (int j = 1; j < start_q.size(); j++) if (start_q[j] - start_q[j - 1] != 10 * CPB) gaps++;
      check("burst_contiguous", 32'(gaps), 32'd0);
      compare_frames("burst");

      // Reset during data bit 3 of 0x3C with two bytes queued behind it.
      @(negedge clk);
      push_byte(8'h3C, 2, w);
      push_byte(8'h11, 2, w);
      push_byte(8'h22, 2, w);
      tx_valid = 1'b0;
      check("mid_start_bit", 32'(tx), 32'd0);
      repeat (16) @(negedge clk);
      check("mid_queued", 32'(fifo_count), 32'd2);
      check("mid_data_bit3", 32'(tx), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(tx_ready), 32'd1);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push_byte(8'h81, 2, w);
      tx_valid = 1'b0;
      wait_idle("post_rst", 200);
      repeat (50) @(negedge clk);
      compare_frames("post_rst");

      // Random bytes with random valid gaps against backpressure.
      track_max = 1'b1;
      for (int k = 0; k < 32; k++) begin
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
         if (gap > 0) begin
            tx_valid = 1'b0;
            tx_data = 8'($urandom);
            repeat (gap) @(negedge clk);
         end
         push_byte(8'($urandom_range(0, 255)), 100, w);
      end
      tx_valid = 1'b0;
      wait_idle("random", 3000);
      track_max = 1'b0;
      check("random_max_count", 32'(max_cnt <= DEPTH), 32'd1);
      compare_frames("random");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
